furv_dmem_responder: RTL and testbench
======================================

// Module: furv_dmem_responder
// PURPOSE
//  Data-memory responder: the slave end of the core's load/store port
//  (mem_en/mem_read/addr/data_out out of the core, data_in back into it).
//  Holds a word-addressed RAM and serves one request at a time after a
//  programmable number of wait states. It reports completion with rvalid and
//  occupancy with busy. Sits between the core and the system bus/SRAM model.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words; must be a power of two
//  ADDR_W       10    log2(DEPTH_WORDS); word-index width
//  WAIT_CYCLES  1     extra cycles between accept and access (0..255)
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  rst_n     in   1   asynchronous active-low reset
//  mem_en    in   1   request strobe from core
//  mem_read  in   1   1 = load, 0 = store; sampled with mem_en
//  addr      in   32  byte address; sampled with mem_en
//  wdata     in   32  store data (core data_out); sampled with mem_en
//  rdata     out  32  load data (core data_in)
//  rvalid    out  1   one-cycle pulse: access completed (load or store)
//  busy      out  1   request in flight; new requests are not accepted
//  err       out  1   only with FURV_DMEM_ERR_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rdata=0, rvalid=0, busy=0, err=0,
//   wait counter=0, any pending store discarded. RAM contents are not reset.
//  FSM states: IDLE, WAIT, ACCESS. busy=1 whenever state!=IDLE.
//   IDLE  : mem_en=1 at edge E0 -> latch addr/wdata/mem_read;
//           go WAIT with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0, else go ACCESS.
//   WAIT  : cnt==0 -> ACCESS; else cnt<=cnt-1.
//   ACCESS: load: rdata<=ram[idx]; store: ram[idx]<=latched wdata.
//           rvalid<=1 for exactly one cycle; go IDLE.
//  Latency: accept at E0, access and rvalid rise at edge E0+1+WAIT_CYCLES.
//  idx = latched addr[ADDR_W+1:2]. addr[1:0] ignored. Upper bits ignored,
//   so the address wraps modulo DEPTH_WORDS*4.
//  rdata holds the last load result until the next load completes.
//   Stores leave rdata unchanged.
//  mem_en while busy=1 is dropped: not queued, no rvalid for it.
//  Back-to-back: mem_en sampled in IDLE while rvalid=1 is accepted.
//  Load of a word stored earlier returns the new value (no forwarding needed,
//   one access in flight).
//  Reset mid-operation: FSM returns to IDLE, store not committed, no rvalid.
// CONFIGURATION
//  FURV_DMEM_ERR_EN defined: in ACCESS, addr[1:0]!=0 or addr>=DEPTH_WORDS*4
//   -> no RAM write, rdata<=0 on load, err<=1 with rvalid (1-cycle pulse).
//   Otherwise err<=0.
//  Not defined: err port absent; addresses wrap and low bits are ignored
//   as above.
// TESTING
//  1 Reset: rst_n=0 mid-WAIT -> rdata=0, rvalid=0, busy=0 immediately;
//    the pending store to 0x10 is absent on the next read.
//  2 WAIT_CYCLES=1: store 0xDEADBEEF @0x40 then load @0x40 -> rvalid 2 edges
//    after each accept; load rdata=0xDEADBEEF.
//  3 WAIT_CYCLES=0: load @0x0 accepted on the same edge rvalid pulses for the
//    prior store -> both complete; no dropped request.
//  4 mem_en pulsed while busy=1 (store 0x1 @0x8) -> ignored; ram[2] unchanged;
//    exactly one rvalid for the original request.
//  5 DEPTH_WORDS=1024: store 0xA5A5A5A5 @0x1000, load @0x0 -> 0xA5A5A5A5
//    (wrap). With ERR_EN: err=1, rdata=0, ram[0] unchanged.
//  6 ERR_EN: load @0x42 -> err=1 with rvalid, rdata=0; next load @0x40
//    -> err=0.

Source files
------------

// File: rtl/furv_dmem_responder.sv
// furv_dmem_responder
// Purpose : slave end of the core load/store port; word-addressed RAM serving
//           one request at a time after WAIT_CYCLES programmable wait states.
// Latency : request accepted at edge E0 is performed, with rvalid raised, at
//           edge E0+1+WAIT_CYCLES; rvalid is a one-cycle pulse.
// Backpr. : busy=1 while a request is in flight; mem_en seen while busy is
//           dropped (not queued, never answered). A request presented while
//           rvalid is high (FSM back in IDLE) is accepted.
// Option  : define FURV_DMEM_ERR_EN to add the err output. In that build a
//           misaligned or out-of-range address suppresses the RAM write,
//           returns zero on loads and pulses err together with rvalid.
//           Without it, addr[1:0] and the bits above the word index are
//           ignored, so addresses wrap modulo DEPTH_WORDS*4.
//
// Ports
//   clk       in   1   clock, all state on posedge
//   rst_n     in   1   asynchronous active-low reset
//   mem_en    in   1   request strobe from the core
//   mem_read  in   1   1 = load, 0 = store (sampled with mem_en)
//   addr      in   32  byte address (sampled with mem_en)
//   wdata     in   32  store data (sampled with mem_en)
//   rdata     out  32  last load result, held until the next load completes
//   rvalid    out  1   access completed (load or store)
//   busy      out  1   request in flight
//   err       out  1   address error, FURV_DMEM_ERR_EN builds only

module furv_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
`ifdef FURV_DMEM_ERR_EN
    output logic        busy,
    output logic        err
`else
    output logic        busy
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // WAIT is entered with cnt=WAIT_CYCLES-1 and leaves when cnt==0, which
    // gives exactly WAIT_CYCLES edges spent in WAIT.
    localparam bit         LP_HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [7:0] LP_CNT_INIT = LP_HAS_WAIT ? 8'(WAIT_CYCLES - 1) : 8'd0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_read;
    logic [31:0]       r_rdata;
    logic              r_rvalid;

    logic              w_accept;
    logic              w_access;
    logic              w_bad;
    logic [ADDR_W-1:0] w_idx;

    // RAM contents are deliberately not reset.
    logic [31:0]       r_ram [DEPTH_WORDS];

    assign w_idx  = r_addr[ADDR_W+1:2];
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = (r_state != S_IDLE);

`ifdef FURV_DMEM_ERR_EN
    // Compare in 33 bits so DEPTH_WORDS*4 == 2^32 cannot overflow.
    localparam logic [32:0] LP_LIMIT = 33'(DEPTH_WORDS) << 2;

    logic r_err;

    assign w_bad = (r_addr[1:0] != 2'b00) || ({1'b0, r_addr} >= LP_LIMIT);
    assign err   = r_err;
`else
    // Byte-lane and upper address bits have no meaning when wrapping.
    logic w_unused;

    assign w_bad    = 1'b0;
    assign w_unused = ^{r_addr[31:ADDR_W+2], r_addr[1:0]};
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LP_HAS_WAIT ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_access    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter, response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 8'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_read   <= 1'b0;
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
`ifdef FURV_DMEM_ERR_EN
            r_err    <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_read  <= mem_read;
                r_cnt   <= LP_CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end

            r_rvalid <= w_access;

            // Stores leave rdata untouched; only a completed load updates it.
            if (w_access && r_read) begin
                r_rdata <= w_bad ? 32'd0 : r_ram[w_idx];
            end
`ifdef FURV_DMEM_ERR_EN
            r_err <= w_access & w_bad;
`endif
        end
    end

    // ------------------------------------------------------------------
    // RAM write port. Reset forces IDLE, so a store caught mid-flight by
    // reset never reaches ACCESS and is never committed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_access && !r_read && !w_bad) begin
            r_ram[w_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_furv_dmem_responder.sv
module tb_furv_dmem_responder;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    // Instance with one wait state
    logic        en1, rd1;
    logic [31:0] addr1, wd1, rdata1;
    logic        rvalid1, busy1;
    // Instance with zero wait states
    logic        en0, rd0;
    logic [31:0] addr0, wd0, rdata0;
    logic        rvalid0, busy0;
`ifdef FURV_DMEM_ERR_EN
    logic        err1, err0;
`endif

    exp_t        sb1[$];
    exp_t        sb0[$];
    exp_t        mon1_it;
    exp_t        mon0_it;
    int          n_vec   = 0;
    int          n_err   = 0;
    int          rv_cnt1 = 0;
    int          rv_cnt0 = 0;
    logic [31:0] last1   = 32'd0;

    always #5 clk = ~clk;

    furv_dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_en   (en1),
        .mem_read (rd1),
        .addr     (addr1),
        .wdata    (wd1),
        .rdata    (rdata1),
        .rvalid   (rvalid1),
`ifdef FURV_DMEM_ERR_EN
        .busy     (busy1),
        .err      (err1)
`else
        .busy     (busy1)
`endif
    );

    furv_dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_en   (en0),
        .mem_read (rd0),
        .addr     (addr0),
        .wdata    (wd0),
        .rdata    (rdata0),
        .rvalid   (rvalid0),
`ifdef FURV_DMEM_ERR_EN
        .busy     (busy0),
        .err      (err0)
`else
        .busy     (busy0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumers: every rvalid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rvalid1) begin
            rv_cnt1++;
            if (sb1.size() == 0) begin
                check("spurious_rv1", 32'(rvalid1), 32'd0);
            end else begin
                mon1_it = sb1.pop_front();
                check("rdata1", rdata1, mon1_it.d);
`ifdef FURV_DMEM_ERR_EN
                check("err1", 32'(err1), 32'(mon1_it.e));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rvalid0) begin
            rv_cnt0++;
            if (sb0.size() == 0) begin
                check("spurious_rv0", 32'(rvalid0), 32'd0);
            end else begin
                mon0_it = sb0.pop_front();
                check("rdata0", rdata0, mon0_it.d);
`ifdef FURV_DMEM_ERR_EN
                check("err0", 32'(err0), 32'(mon0_it.e));
`endif
            end
        end
    end

    // One request to the one-wait-state instance; called at a negedge.
    task automatic req1(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
        exp_t it;
        int   n;
        it.d = rd ? exp_d : last1;
        it.e = exp_e;
        if (rd) last1 = exp_d;
        sb1.push_back(it);
        en1 = 1'b1; rd1 = rd; addr1 = a; wd1 = wd;
        @(posedge clk); #1;
        en1 = 1'b0;
        check("accept_busy1", 32'(busy1), 32'd1);
        n = 0;
        while (!rvalid1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("lat1", 32'(n), 32'd2);
        @(posedge clk); #1;
        check("rv1_one_cycle", 32'(rvalid1), 32'd0);
        check("idle_busy1", 32'(busy1), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t it;
        int   n;
        int   base;
        rst_n = 1'b0;
        en1 = 1'b0; rd1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0;
        en0 = 1'b0; rd0 = 1'b0; addr0 = 32'd0; wd0 = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_rvalid1", 32'(rvalid1), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
`ifdef FURV_DMEM_ERR_EN
        check("rst_err1", 32'(err1), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Store then load, one wait state
        req1(1'b0, 32'h40, 32'hDEADBEEF, 32'd0, 1'b0);
        req1(1'b1, 32'h40, 32'd0, 32'hDEADBEEF, 1'b0);
`ifdef FURV_DMEM_ERR_EN
        req1(1'b1, 32'h42, 32'd0, 32'd0, 1'b1);
        req1(1'b1, 32'h40, 32'd0, 32'hDEADBEEF, 1'b0);
`else
        req1(1'b1, 32'h42, 32'd0, 32'hDEADBEEF, 1'b0);
        req1(1'b1, 32'h1040, 32'd0, 32'hDEADBEEF, 1'b0);
`endif

        // Reset in the middle of WAIT discards the pending store
        req1(1'b0, 32'h10, 32'h0BADF00D, 32'd0, 1'b0);
        req1(1'b1, 32'h10, 32'd0, 32'h0BADF00D, 1'b0);
        en1 = 1'b1; rd1 = 1'b0; addr1 = 32'h10; wd1 = 32'h11111111;
        @(posedge clk); #1;
        en1 = 1'b0;
        check("midwait_busy1", 32'(busy1), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rdata1", rdata1, 32'd0);
        check("midrst_rvalid1", 32'(rvalid1), 32'd0);
        check("midrst_busy1", 32'(busy1), 32'd0);
        last1 = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req1(1'b1, 32'h10, 32'd0, 32'h0BADF00D, 1'b0);

        // Request while busy is dropped
        req1(1'b0, 32'h8, 32'hCAFEF00D, 32'd0, 1'b0);
        base = rv_cnt1;
        it.d = last1; it.e = 1'b0;
        sb1.push_back(it);
        en1 = 1'b1; rd1 = 1'b0; addr1 = 32'hC; wd1 = 32'h77777777;
        @(posedge clk); #1;
        en1 = 1'b0;
        @(negedge clk);
        check("drop_busy1", 32'(busy1), 32'd1);
        en1 = 1'b1; rd1 = 1'b0; addr1 = 32'h8; wd1 = 32'h1;
        @(posedge clk); #1;
        en1 = 1'b0;
        repeat (6) @(negedge clk);
        check("drop_rvcnt1", 32'(rv_cnt1 - base), 32'd1);
        req1(1'b1, 32'h8, 32'd0, 32'hCAFEF00D, 1'b0);
        req1(1'b1, 32'hC, 32'd0, 32'h77777777, 1'b0);

        // Address wrap / range error
        req1(1'b0, 32'h0, 32'h5A5A0000, 32'd0, 1'b0);
`ifdef FURV_DMEM_ERR_EN
        req1(1'b0, 32'h1000, 32'hA5A5A5A5, 32'd0, 1'b1);
        req1(1'b1, 32'h1000, 32'd0, 32'd0, 1'b1);
        req1(1'b1, 32'h0, 32'd0, 32'h5A5A0000, 1'b0);
`else
        req1(1'b0, 32'h1000, 32'hA5A5A5A5, 32'd0, 1'b0);
        req1(1'b1, 32'h0, 32'd0, 32'hA5A5A5A5, 1'b0);
`endif

        // Zero wait states: back-to-back store then load
        base = rv_cnt0;
        it.d = 32'd0; it.e = 1'b0;
        sb0.push_back(it);
        en0 = 1'b1; rd0 = 1'b0; addr0 = 32'h0; wd0 = 32'h12345678;
        @(posedge clk); #1;
        en0 = 1'b0;
        n = 0;
        while (!rvalid0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("lat0_store", 32'(n), 32'd1);
        check("b2b_busy0", 32'(busy0), 32'd0);
        it.d = 32'h12345678; it.e = 1'b0;
        sb0.push_back(it);
        en0 = 1'b1; rd0 = 1'b1; addr0 = 32'h0;
        @(posedge clk); #1;
        en0 = 1'b0;
        check("b2b_accept0", 32'(busy0), 32'd1);
        n = 0;
        while (!rvalid0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("lat0_load", 32'(n), 32'd1);
        repeat (4) @(negedge clk);
        check("b2b_rvcnt0", 32'(rv_cnt0 - base), 32'd2);

        check("sb1_drained", 32'(sb1.size()), 32'd0);
        check("sb0_drained", 32'(sb0.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
